warp_pc_unit: RTL and testbench

WARP_PC_UNIT -- requirements
Module: warp_pc_unit

---
 rtl/gpu_pkg.sv | 24 ++
 rtl/simt_stack.sv | 50 +++++
 rtl/warp_pc_unit.sv | 159 +++++++++++++++
 tb/tb_warp_pc_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the warp PC unit: core phase encodings, divergence phase and stack entry.
// The stack entry is sized for the widest supported PC_WIDTH/THREADS; narrower instances use the low bits.
package gpu_pkg;

  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  localparam int MAX_PC_WIDTH = 16;
  localparam int MAX_THREADS  = 32;

  typedef enum logic {
    ALT_PENDING = 1'b0,
    JOIN        = 1'b1
  } phase_e;

  typedef struct packed {
    logic [MAX_THREADS-1:0]  saved_mask;
    logic [MAX_PC_WIDTH-1:0] alt_pc;
    logic [MAX_THREADS-1:0]  alt_mask;
    logic [MAX_PC_WIDTH-1:0] join_pc;
    phase_e                  phase;
  } stack_entry_t;

endpackage

// File: rtl/simt_stack.sv
// SIMT divergence stack: push, pop and in-place rewrite of the top entry.
// Entry contents are not cleared by reset; only the stack pointer is.
module simt_stack
  import gpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               top_write,
  input  stack_entry_t       push_entry,
  input  stack_entry_t       top_entry_in,
  output stack_entry_t       top_entry,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W-1:0] depth
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  stack_entry_t       mem [DEPTH];
  logic [DEPTH_W-1:0] sp;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   top_idx;

  assign wr_idx    = sp[IDX_W-1:0];
  assign top_idx   = IDX_W'(sp - 1'b1);
  assign top_entry = mem[top_idx];
  assign full      = (sp == DEPTH_W'(DEPTH));
  assign empty     = (sp == '0);
  assign depth     = sp;

  // Only one operation per cycle; the caller never asserts more than one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_entry;
      sp          <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end else if (top_write && !empty) begin
      mem[top_idx] <= top_entry_in;
    end
  end

endmodule

// File: rtl/warp_pc_unit.sv
// Warp program-counter unit: shared PC for THREADS lanes with per-lane NZP flags.
// Define WARP_PC_DIVERGENCE_EN to add the SIMT divergence stack (otherwise divergent branches fall through).
module warp_pc_unit
  import gpu_pkg::*;
#(
  parameter int PC_WIDTH    = 8,
  parameter int THREADS     = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic                             nzp_write_en,
  input  logic [3*THREADS-1:0]             alu_nzp,
  input  logic                             branch_en,
  input  logic                             sync_en,
  input  logic [2:0]                       inst_nzp,
  input  logic [PC_WIDTH-1:0]              current_pc,
  input  logic [PC_WIDTH-1:0]              immediate,
  output logic [PC_WIDTH-1:0]              updated_pc,
  output logic [THREADS-1:0]               active_mask,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
  output logic                             stack_overflow
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [2:0]          nzp_reg [THREADS];
  logic [PC_WIDTH-1:0] pc_q, pc_d, next_pc;
  logic [THREADS-1:0]  mask_q, mask_d, taken;
  logic                is_exec;

  assign is_exec     = (core_state == CORE_EXECUTE);
  assign next_pc     = current_pc + 1'b1;
  assign updated_pc  = pc_q;
  assign active_mask = mask_q;

  // Flags latch only for active lanes so a parked path keeps its own condition codes.
  always_ff @(posedge clk) begin
    for (int t = 0; t < THREADS; t++) begin
      if (reset) begin
        nzp_reg[t] <= 3'b000;
      end else if (core_state == CORE_UPDATE && nzp_write_en && mask_q[t]) begin
        nzp_reg[t] <= alu_nzp[3*t +: 3];
      end
    end
  end

  always_comb begin
    taken = '0;
    for (int t = 0; t < THREADS; t++) begin
      taken[t] = mask_q[t] & (|(inst_nzp & nzp_reg[t]));
    end
  end

`ifdef WARP_PC_DIVERGENCE_EN
  stack_entry_t       push_entry, top_entry_in, top_entry;
  logic               stk_push, stk_pop, stk_top_wr, stk_full, stk_empty;
  logic [DEPTH_W-1:0] stk_depth;
  logic               ovf_q, ovf_set;
  logic               unused_top;

  simt_stack #(
    .DEPTH   (STACK_DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_stack (
    .clk          (clk),
    .reset        (reset),
    .push         (stk_push),
    .pop          (stk_pop),
    .top_write    (stk_top_wr),
    .push_entry   (push_entry),
    .top_entry_in (top_entry_in),
    .top_entry    (top_entry),
    .full         (stk_full),
    .empty        (stk_empty),
    .depth        (stk_depth)
  );

  assign unused_top     = ^top_entry;
  assign stack_depth    = stk_depth;
  assign stack_overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end
  end
`else
  assign stack_depth    = '0;
  assign stack_overflow = 1'b0;
`endif

  always_comb begin
    pc_d   = pc_q;
    mask_d = mask_q;
`ifdef WARP_PC_DIVERGENCE_EN
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_top_wr = 1'b0;
    ovf_set    = 1'b0;
    push_entry            = '0;
    push_entry.saved_mask = MAX_THREADS'(mask_q);
    push_entry.alt_pc     = MAX_PC_WIDTH'(next_pc);
    push_entry.alt_mask   = MAX_THREADS'(mask_q & ~taken);
    push_entry.phase      = ALT_PENDING;
    top_entry_in          = top_entry;
    top_entry_in.join_pc  = MAX_PC_WIDTH'(next_pc);
    top_entry_in.phase    = JOIN;
`endif
    if (is_exec) begin
      pc_d = next_pc;
      if (sync_en) begin
`ifdef WARP_PC_DIVERGENCE_EN
        // First SYNC switches to the parked path; the second reconverges.
        if (!stk_empty) begin
          if (top_entry.phase == ALT_PENDING) begin
            stk_top_wr = 1'b1;
            mask_d     = top_entry.alt_mask[THREADS-1:0];
            pc_d       = top_entry.alt_pc[PC_WIDTH-1:0];
          end else begin
            stk_pop = 1'b1;
            mask_d  = top_entry.saved_mask[THREADS-1:0];
            pc_d    = top_entry.join_pc[PC_WIDTH-1:0];
          end
        end
`endif
      end else if (branch_en) begin
        if (taken == mask_q) begin
          pc_d = immediate;
        end
`ifdef WARP_PC_DIVERGENCE_EN
        else if (taken != '0) begin
          if (!stk_full) begin
            stk_push = 1'b1;
            mask_d   = taken;
            pc_d     = immediate;
          end else begin
            ovf_set = 1'b1;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      mask_q <= '1;
    end else if (is_exec) begin
      pc_q   <= pc_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: tb/tb_warp_pc_unit.sv
// Self-checking bench for warp_pc_unit: directed scenarios plus random traffic against a queue-based model.
// Works with and without WARP_PC_DIVERGENCE_EN; divergence-specific constants are checked only when it is defined.
module tb_warp_pc_unit;
  import gpu_pkg::*;

  localparam int PC_WIDTH    = 8;
  localparam int THREADS     = 4;
  localparam int STACK_DEPTH = 2;
  localparam int DW          = $clog2(STACK_DEPTH + 1);
  localparam int EW          = PC_WIDTH + THREADS + DW + 1;
`ifdef WARP_PC_DIVERGENCE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]           core_state = 3'b000;
  logic                 nzp_write_en = 1'b0;
  logic [3*THREADS-1:0] alu_nzp = '0;
  logic                 branch_en = 1'b0;
  logic                 sync_en = 1'b0;
  logic [2:0]           inst_nzp = 3'b000;
  logic [PC_WIDTH-1:0]  current_pc = '0;
  logic [PC_WIDTH-1:0]  immediate = '0;
  logic [PC_WIDTH-1:0]  updated_pc;
  logic [THREADS-1:0]   active_mask;
  logic [DW-1:0]        stack_depth;
  logic                 stack_overflow;

  warp_pc_unit #(
    .PC_WIDTH    (PC_WIDTH),
    .THREADS     (THREADS),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .core_state     (core_state),
    .nzp_write_en   (nzp_write_en),
    .alu_nzp        (alu_nzp),
    .branch_en      (branch_en),
    .sync_en        (sync_en),
    .inst_nzp       (inst_nzp),
    .current_pc     (current_pc),
    .immediate      (immediate),
    .updated_pc     (updated_pc),
    .active_mask    (active_mask),
    .stack_depth    (stack_depth),
    .stack_overflow (stack_overflow)
  );

  // reference model
  typedef struct {
    logic [PC_WIDTH-1:0] alt_pc;
    logic [PC_WIDTH-1:0] join_pc;
    logic [THREADS-1:0]  saved_mask;
    logic [THREADS-1:0]  alt_mask;
    bit                  joined;
  } m_entry_t;

  m_entry_t            m_stack[$];
  logic [PC_WIDTH-1:0] m_pc;
  logic [THREADS-1:0]  m_mask;
  logic [2:0]          m_nzp [THREADS];
  bit                  m_ovf;
  logic [EW-1:0]       exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_pc   = '0;
    m_mask = '1;
    m_ovf  = 1'b0;
    for (int t = 0; t < THREADS; t++) m_nzp[t] = 3'b000;
  endtask

  task automatic model_step();
    logic [PC_WIDTH-1:0] np;
    logic [THREADS-1:0]  tk;
    m_entry_t            e;
    np = PC_WIDTH'(current_pc + 1);
    tk = '0;
    for (int t = 0; t < THREADS; t++)
      if (m_mask[t] && ((inst_nzp & m_nzp[t]) != 3'b000)) tk[t] = 1'b1;
    if (core_state == CORE_UPDATE && nzp_write_en) begin
      for (int t = 0; t < THREADS; t++)
        if (m_mask[t]) m_nzp[t] = alu_nzp[3*t +: 3];
    end else if (core_state == CORE_EXECUTE) begin
      if (sync_en) begin
        if (DIV_EN && m_stack.size() > 0) begin
          e = m_stack.pop_back();
          if (!e.joined) begin
            e.joined  = 1'b1;
            e.join_pc = np;
            m_mask    = e.alt_mask;
            m_pc      = e.alt_pc;
            m_stack.push_back(e);
          end else begin
            m_mask = e.saved_mask;
            m_pc   = e.join_pc;
          end
        end else begin
          m_pc = np;
        end
      end else if (branch_en) begin
        if (tk == m_mask) begin
          m_pc = immediate;
        end else if (tk == '0) begin
          m_pc = np;
        end else if (DIV_EN && m_stack.size() < STACK_DEPTH) begin
          e.saved_mask = m_mask;
          e.alt_pc     = np;
          e.alt_mask   = m_mask & ~tk;
          e.join_pc    = '0;
          e.joined     = 1'b0;
          m_stack.push_back(e);
          m_mask = tk;
          m_pc   = immediate;
        end else begin
          if (DIV_EN) m_ovf = 1'b1;
          m_pc = np;
        end
      end else begin
        m_pc = np;
      end
    end
  endtask

  task automatic compare(input string tag);
    logic [EW-1:0] e;
    check_eq({tag, ".queued"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, ".pc"},    32'(updated_pc),     32'(e[PC_WIDTH-1:0]));
      check_eq({tag, ".mask"},  32'(active_mask),    32'(e[PC_WIDTH +: THREADS]));
      check_eq({tag, ".depth"}, 32'(stack_depth),    32'(e[PC_WIDTH+THREADS +: DW]));
      check_eq({tag, ".ovf"},   32'(stack_overflow), 32'(e[EW-1]));
    end
  endtask

  // driver tasks
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    exp_q.push_back({m_ovf, DW'(m_stack.size()), m_mask, m_pc});
    @(posedge clk);
    #1;
    compare(tag);
    reset = 1'b0;
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic we,
                      input logic [3*THREADS-1:0] alu, input logic br, input logic sy,
                      input logic [2:0] inz, input logic [PC_WIDTH-1:0] pc,
                      input logic [PC_WIDTH-1:0] imm);
    @(negedge clk);
    core_state   = st;
    nzp_write_en = we;
    alu_nzp      = alu;
    branch_en    = br;
    sync_en      = sy;
    inst_nzp     = inz;
    current_pc   = pc;
    immediate    = imm;
    model_step();
    exp_q.push_back({m_ovf, DW'(m_stack.size()), m_mask, m_pc});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    logic [2:0] st;
    do_reset("reset0");
    check_eq("reset0.pc_zero", 32'(updated_pc), 32'h0);
    check_eq("reset0.mask_ones", 32'(active_mask), 32'hF);

    // PC wrap on a plain instruction
    step("wrap", CORE_EXECUTE, 1'b0, '0, 1'b0, 1'b0, 3'b000, 8'hFF, 8'h00);
    check_eq("wrap.pc_const", 32'(updated_pc), 32'h00);

    // uniform branch, mask-match on z
    step("upd_all_z", CORE_UPDATE, 1'b1, 12'b010_010_010_010, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    step("uniform", CORE_EXECUTE, 1'b0, '0, 1'b1, 1'b0, 3'b011, 8'h30, 8'h20);
    check_eq("uniform.pc_const", 32'(updated_pc), 32'h20);
    check_eq("uniform.mask_const", 32'(active_mask), 32'hF);
    check_eq("uniform.depth_const", 32'(stack_depth), 32'h0);

    // divergence, partial flag update, reconvergence
    step("upd_split", CORE_UPDATE, 1'b1, 12'b001_001_100_100, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    step("div_br", CORE_EXECUTE, 1'b0, '0, 1'b1, 1'b0, 3'b100, 8'h05, 8'h10);
`ifdef WARP_PC_DIVERGENCE_EN
    check_eq("div_br.pc_const", 32'(updated_pc), 32'h10);
    check_eq("div_br.mask_const", 32'(active_mask), 32'h3);
    check_eq("div_br.depth_const", 32'(stack_depth), 32'h1);
`endif
    step("upd_masked", CORE_UPDATE, 1'b1, 12'b010_010_010_010, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    step("sync_alt", CORE_EXECUTE, 1'b0, '0, 1'b0, 1'b1, 3'b000, 8'h14, 8'h00);
`ifdef WARP_PC_DIVERGENCE_EN
    check_eq("sync_alt.pc_const", 32'(updated_pc), 32'h06);
    check_eq("sync_alt.mask_const", 32'(active_mask), 32'hC);
`endif
    step("sync_join", CORE_EXECUTE, 1'b0, '0, 1'b0, 1'b1, 3'b000, 8'h0F, 8'h00);
`ifdef WARP_PC_DIVERGENCE_EN
    check_eq("sync_join.pc_const", 32'(updated_pc), 32'h15);
    check_eq("sync_join.mask_const", 32'(active_mask), 32'hF);
    check_eq("sync_join.depth_const", 32'(stack_depth), 32'h0);
`endif
    // lanes 2,3 must still hold 001 from before the masked update
    step("held_lanes", CORE_EXECUTE, 1'b0, '0, 1'b1, 1'b0, 3'b010, 8'h40, 8'h50);
`ifdef WARP_PC_DIVERGENCE_EN
    check_eq("held_lanes.mask_const", 32'(active_mask), 32'h3);
`endif
    step("held_sync1", CORE_EXECUTE, 1'b0, '0, 1'b0, 1'b1, 3'b000, 8'h51, 8'h00);
    step("held_sync2", CORE_EXECUTE, 1'b0, '0, 1'b0, 1'b1, 3'b000, 8'h44, 8'h00);

    // nesting past the stack capacity
    step("upd_nest", CORE_UPDATE, 1'b1, 12'b000_001_010_100, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    step("nest1", CORE_EXECUTE, 1'b0, '0, 1'b1, 1'b0, 3'b111, 8'h60, 8'h70);
    step("nest2", CORE_EXECUTE, 1'b0, '0, 1'b1, 1'b0, 3'b110, 8'h70, 8'h80);
    step("nest3", CORE_EXECUTE, 1'b0, '0, 1'b1, 1'b0, 3'b100, 8'h80, 8'h90);
`ifdef WARP_PC_DIVERGENCE_EN
    check_eq("nest3.depth_const", 32'(stack_depth), 32'(STACK_DEPTH));
    check_eq("nest3.ovf_const", 32'(stack_overflow), 32'h1);
    check_eq("nest3.pc_const", 32'(updated_pc), 32'h81);
`endif
    step("hold_other", 3'b011, 1'b1, 12'hFFF, 1'b1, 1'b1, 3'b111, 8'h12, 8'h34);

    do_reset("reset_mid");
    check_eq("reset_mid.pc_const", 32'(updated_pc), 32'h0);
    check_eq("reset_mid.mask_const", 32'(active_mask), 32'hF);
    check_eq("reset_mid.depth_const", 32'(stack_depth), 32'h0);
    check_eq("reset_mid.ovf_const", 32'(stack_overflow), 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset("rnd_reset");
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: st = CORE_EXECUTE;
          6, 7:             st = CORE_UPDATE;
          default:          st = 3'($urandom_range(0, 7));
        endcase
        step("rnd", st, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
